// File: rtl/program_counter_pkg.sv
// program_counter_pkg: command encoding and address-wrap helper shared by
// program_counter_stack and its return stack.
package program_counter_pkg;

    // One command acts per cycle, chosen by the top-level priority encoder.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_SET,
        PC_CALL,
        PC_RET,
        PC_BRANCH,
        PC_INC
    } pc_cmd_e;

    // Sequential successor address. Anything at or above the limit wraps to 0,
    // so an out-of-range load also wraps on its next increment.
    function automatic logic [31:0] pc_wrap_inc(input logic [31:0] value,
                                                input logic [31:0] limit);
        return (value >= limit) ? 32'd0 : value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: circular return-address stack. Pushing into a full stack
// overwrites the oldest entry; popping an empty stack changes nothing. Both
// cases raise a one-cycle combinational pulse for the caller to register.
module pc_return_stack
    import program_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    nxt_ptr, top_ptr;
    logic [DW-1:0]    depth_q, depth_d;

    assign nxt_ptr = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    assign top_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - PW'(1);

    assign pop_data_o  = mem_q[top_ptr];
    assign full_o      = (depth_q == DW'(DEPTH));
    assign empty_o     = (depth_q == '0);
    assign overflow_o  = push_i & full_o;
    assign underflow_o = pop_i & empty_o & ~push_i;

    // Pointer and occupancy update; a full push advances the pointer but keeps depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        depth_d  = depth_q;
        if (push_i) begin
            wr_ptr_d = nxt_ptr;
            if (!full_o) begin
                depth_d = depth_q + DW'(1);
            end
        end else if (pop_i && !empty_o) begin
            wr_ptr_d = top_ptr;
            depth_d  = depth_q - DW'(1);
        end
    end

    // Pointer and depth registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            depth_q  <= depth_d;
        end
    end

    // Entry storage; contents after reset are irrelevant because depth is 0.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch-address counter with stall, absolute load,
// signed relative branch and a hardware call/return stack.
// Optional macro PROGRAM_COUNTER_STACK_ERR_EN enables the sticky
// overflow/underflow flags; without it they read 0 and err_clr is ignored.
module program_counter_stack
    import program_counter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned COUNT_LIMIT = 255,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   set,
    input  logic [COUNT_WIDTH-1:0] set_value,
    input  logic                   branch,
    input  logic [COUNT_WIDTH-1:0] offset,
    input  logic                   call,
    input  logic                   ret,
    input  logic                   err_clr,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned BW = COUNT_WIDTH + 2;
    localparam logic signed [BW-1:0] LIMIT_S = BW'(COUNT_LIMIT);
    localparam logic signed [BW-1:0] SPAN_S  = BW'(COUNT_LIMIT + 1);

    pc_cmd_e                 cmd;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [COUNT_WIDTH-1:0]  inc_val;
    logic [COUNT_WIDTH-1:0]  stk_top;
    logic signed [BW-1:0]    br_sum, br_fix;
    logic                    stk_push, stk_pop;
    logic                    stk_empty, stk_full, stk_ovf, stk_unf;
    logic                    unused_bits;

    assign inc_val = COUNT_WIDTH'(pc_wrap_inc(32'(count_q), COUNT_LIMIT));
    assign br_sum  = $signed({2'b00, count_q})
                   + $signed({{2{offset[COUNT_WIDTH-1]}}, offset});

    // Priority encoder: set beats the stall, everything else needs en.
    always_comb begin
        if (set) begin
            cmd = PC_SET;
        end else if (!en) begin
            cmd = PC_HOLD;
        end else if (call) begin
            cmd = PC_CALL;
        end else if (ret) begin
            cmd = PC_RET;
        end else if (branch) begin
            cmd = PC_BRANCH;
        end else begin
            cmd = PC_INC;
        end
    end

    // Branch target folded back into 0..COUNT_LIMIT with a single correction.
    always_comb begin
        if (br_sum[BW-1]) begin
            br_fix = br_sum + SPAN_S;
        end else if (br_sum > LIMIT_S) begin
            br_fix = br_sum - SPAN_S;
        end else begin
            br_fix = br_sum;
        end
    end

    // Next-count mux; a return on an empty stack falls back to an increment.
    always_comb begin
        count_d = count_q;
        case (cmd)
            PC_SET, PC_CALL: count_d = set_value;
            PC_RET:          count_d = stk_empty ? inc_val : stk_top;
            PC_BRANCH:       count_d = br_fix[COUNT_WIDTH-1:0];
            PC_INC:          count_d = inc_val;
            default:         count_d = count_q;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= COUNT_WIDTH'(RESET_VALUE);
        end else begin
            count_q <= count_d;
        end
    end

    assign stk_push = (cmd == PC_CALL);
    assign stk_pop  = (cmd == PC_RET);

    pc_return_stack #(
        .WIDTH (COUNT_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (inc_val),
        .pop_data_o  (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty),
        .overflow_o  (stk_ovf),
        .underflow_o (stk_unf)
    );

    assign count       = count_q;
    assign stack_empty = stk_empty;
    assign stack_full  = stk_full;

`ifdef PROGRAM_COUNTER_STACK_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky flags; a new event in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = stk_ovf | (overflow_q & ~err_clr);
        underflow_d = stk_unf | (underflow_q & ~err_clr);
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign unused_bits = ^br_fix[BW-1:COUNT_WIDTH];
`else
    assign overflow    = 1'b0;
    assign underflow   = 1'b0;
    assign unused_bits = ^{br_fix[BW-1:COUNT_WIDTH], err_clr, stk_ovf, stk_unf};
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: directed sequences, a vector
// table, and a randomized phase compared against a queue-based reference model.
module tb_program_counter_stack;

    localparam int LIMIT = 255;
    localparam int DEPTH = 4;
`ifdef PROGRAM_COUNTER_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, set, call, ret, branch, err_clr;
    logic [7:0] set_value, offset;
    logic [7:0] count;
    logic       stack_empty, stack_full, overflow, underflow;

    logic       en9;
    logic       tie0 = 1'b0;
    logic [7:0] tie_v = '0;
    logic [7:0] count9;
    logic       e9, f9, o9, u9;

    int checks = 0;
    int errors = 0;

    int m_count;
    int m_stack[$];
    bit m_ovf, m_unf;

    typedef struct {
        bit       en, set, call, ret, branch;
        bit [7:0] sv, off;
        int       exp_count;
        bit       exp_empty;
    } vec_t;

    vec_t tbl[17];

    always #5 clk = ~clk;

    program_counter_stack #(
        .COUNT_WIDTH (8),
        .COUNT_LIMIT (255),
        .RESET_VALUE (0),
        .STACK_DEPTH (4)
    ) dut (
        .clk (clk), .rst_n (rst_n), .en (en), .set (set), .set_value (set_value),
        .branch (branch), .offset (offset), .call (call), .ret (ret), .err_clr (err_clr),
        .count (count), .stack_empty (stack_empty), .stack_full (stack_full),
        .overflow (overflow), .underflow (underflow)
    );

    program_counter_stack #(
        .COUNT_WIDTH (8),
        .COUNT_LIMIT (9),
        .RESET_VALUE (0),
        .STACK_DEPTH (2)
    ) dut9 (
        .clk (clk), .rst_n (rst_n), .en (en9), .set (tie0), .set_value (tie_v),
        .branch (tie0), .offset (tie_v), .call (tie0), .ret (tie0), .err_clr (tie0),
        .count (count9), .stack_empty (e9), .stack_full (f9),
        .overflow (o9), .underflow (u9)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Reference behaviour from the command rules, using a queue as the stack.
    task automatic model_step();
        bit ov = 1'b0;
        bit un = 1'b0;
        int nxt;
        int t;
        nxt = (m_count >= LIMIT) ? 0 : m_count + 1;
        if (set) begin
            m_count = int'(set_value);
        end else if (en) begin
            if (call) begin
                if (m_stack.size() == DEPTH) begin
                    m_stack.delete(0);
                    ov = 1'b1;
                end
                m_stack.push_back(nxt);
                m_count = int'(set_value);
            end else if (ret) begin
                if (m_stack.size() != 0) begin
                    m_count = m_stack.pop_back();
                end else begin
                    m_count = nxt;
                    un = 1'b1;
                end
            end else if (branch) begin
                t = m_count + int'($signed(offset));
                if (t < 0) t = t + LIMIT + 1;
                else if (t > LIMIT) t = t - (LIMIT + 1);
                m_count = t;
            end else begin
                m_count = nxt;
            end
        end
        if (ERR) begin
            m_ovf = ov | (m_ovf & ~err_clr);
            m_unf = un | (m_unf & ~err_clr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drive(input bit e, input bit s, input bit c, input bit r, input bit b,
                         input bit ec, input logic [7:0] sv, input logic [7:0] off);
        en = e; set = s; call = c; ret = r; branch = b; err_clr = ec;
        set_value = sv; offset = off;
    endtask

    task automatic op(input bit e, input bit s, input bit c, input bit r, input bit b,
                      input bit ec, input logic [7:0] sv, input logic [7:0] off);
        drive(e, s, c, r, b, ec, sv, off);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en9 = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", stack_empty, 1);
        chk("reset_full", stack_full, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_unf", underflow, 0);
        chk("reset_count9", count9, 0);
        chk("reset_empty9", e9, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running increment across the wrap, on both limits.
        en = 1'b1;
        en9 = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            tick();
            chk("inc_count", count, i % 256);
            chk("inc_count9", count9, i % 10);
        end
        en9 = 1'b0;
        chk("inc_end4", count, 4);
        chk("flags9_quiet", {f9, o9, u9}, 0);

        // Stall at 20.
        op(0, 1, 0, 0, 0, 0, 8'd20, 8'd0);
        chk("stall_load", count, 20);
        for (int i = 0; i < 5; i++) begin
            op(0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
            chk("stall_hold", count, 20);
        end

        // Vector table: nested calls, branch wrap, stall, priority.
        tbl[0]  = '{1, 1, 0, 0, 0, 8'd5,   8'd0,   5,    1};
        tbl[1]  = '{1, 0, 1, 0, 0, 8'h40,  8'd0,   'h40, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 8'd0,   8'd0,   'h41, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 8'd0,   8'd0,   'h42, 0};
        tbl[4]  = '{1, 0, 1, 0, 0, 8'h80,  8'd0,   'h80, 0};
        tbl[5]  = '{1, 0, 0, 1, 0, 8'd0,   8'd0,   'h43, 0};
        tbl[6]  = '{1, 0, 0, 1, 0, 8'd0,   8'd0,   6,    1};
        tbl[7]  = '{1, 1, 0, 0, 0, 8'd10,  8'd0,   10,   1};
        tbl[8]  = '{1, 0, 0, 0, 1, 8'd0,   8'hF0,  250,  1};
        tbl[9]  = '{1, 0, 0, 0, 1, 8'd0,   8'd10,  4,    1};
        tbl[10] = '{0, 0, 1, 1, 1, 8'd99,  8'd5,   4,    1};
        tbl[11] = '{0, 1, 0, 0, 0, 8'd128, 8'd0,   128,  1};
        tbl[12] = '{1, 1, 1, 0, 1, 8'd7,   8'd3,   7,    1};
        tbl[13] = '{1, 0, 1, 0, 0, 8'h20,  8'd0,   'h20, 0};
        tbl[14] = '{1, 1, 1, 1, 0, 8'd3,   8'd0,   3,    0};
        tbl[15] = '{1, 0, 0, 1, 0, 8'd0,   8'd0,   8,    1};
        tbl[16] = '{1, 0, 0, 1, 1, 8'd0,   8'h50,  9,    1};
        for (int i = 0; i < 17; i++) begin
            op(tbl[i].en, tbl[i].set, tbl[i].call, tbl[i].ret, tbl[i].branch, 0,
               tbl[i].sv, tbl[i].off);
            chk($sformatf("vec%0d_count", i), count, tbl[i].exp_count);
            chk($sformatf("vec%0d_empty", i), stack_empty, int'(tbl[i].exp_empty));
        end

        // Overflow / underflow / err_clr sequence.
        do_reset();
        op(1, 1, 0, 0, 0, 0, 8'd1, 8'd0);
        op(1, 0, 1, 0, 0, 0, 8'd10, 8'd0);
        op(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        op(1, 0, 1, 0, 0, 0, 8'd20, 8'd0);
        op(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        op(1, 0, 1, 0, 0, 0, 8'd30, 8'd0);
        op(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        op(1, 0, 1, 0, 0, 0, 8'd40, 8'd0);
        chk("four_calls_full", stack_full, 1);
        chk("four_calls_noovf", overflow, 0);
        op(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        chk("pre_ovf_count", count, 41);
        op(1, 0, 1, 0, 0, 0, 8'd50, 8'd0);
        chk("ovf_count", count, 50);
        chk("ovf_full", stack_full, 1);
        chk("ovf_flag", overflow, int'(ERR));
        op(1, 0, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("ret1", count, 42);
        op(1, 0, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("ret2", count, 32);
        op(1, 0, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("ret3", count, 22);
        op(1, 0, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("ret4", count, 12);
        chk("ret4_empty", stack_empty, 1);
        chk("ret4_nounf", underflow, 0);
        op(1, 0, 0, 1, 0, 0, 8'd0, 8'd0);
        chk("unf_count", count, 13);
        chk("unf_flag", underflow, int'(ERR));
        chk("ovf_sticky", overflow, int'(ERR));
        op(0, 0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);
        chk("clr_count_hold", count, 13);
        op(1, 0, 0, 1, 0, 1, 8'd0, 8'd0);
        chk("clr_vs_event_unf", underflow, int'(ERR));
        chk("clr_vs_event_count", count, 14);
        op(1, 0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("clr2_unf", underflow, 0);

        // Asynchronous reset between edges while a call is being presented.
        op(1, 0, 1, 0, 0, 0, 8'h30, 8'd0);
        chk("pre_areset_empty", stack_empty, 0);
        drive(1, 0, 1, 0, 0, 0, 8'h55, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_count", count, 0);
        chk("areset_empty", stack_empty, 1);
        chk("areset_full", stack_full, 0);
        drive(0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized commands against the reference model.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 5) == 0,
                  ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 12) == 0,
                  8'($urandom), 8'($urandom));
            tick();
            chk("rnd_count", count, m_count);
            chk("rnd_empty", stack_empty, int'(m_stack.size() == 0));
            chk("rnd_full", stack_full, int'(m_stack.size() == DEPTH));
            chk("rnd_ovf", overflow, int'(m_ovf));
            chk("rnd_unf", underflow, int'(m_unf));
        end
        drive(0, 0, 0, 0, 0, 0, 8'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
